// File: rtl/cmp_branch_seq_pkg.sv
// Shared types and helpers for the chunked branch comparator.
// The relation codes, the FSM states and the relation resolver live here.
package cmp_branch_pkg;

  typedef enum logic [2:0] {
    MODE_EQ  = 3'b000,
    MODE_NE  = 3'b001,
    MODE_LT  = 3'b010,
    MODE_GE  = 3'b011,
    MODE_LTU = 3'b100,
    MODE_GEU = 3'b101
  } cmp_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Codes 11x are not defined relations.
  function automatic logic is_reserved(input logic [2:0] mode);
    return (mode[2:1] == 2'b11);
  endfunction

  // Signed relations flip the sign bit of the top chunk before comparing.
  function automatic logic is_signed_mode(input logic [2:0] mode);
    return (mode == MODE_LT) || (mode == MODE_GE);
  endfunction

  // Returns {taken, notTaken}. When the operands are equal, lt is 0,
  // so the same table covers both the early-exit and the all-equal case.
  function automatic logic [1:0] resolve(input logic [2:0] mode,
                                         input logic eq,
                                         input logic lt);
    logic [1:0] r;
    r = 2'b01;
    case (mode)
      MODE_EQ:  r = eq ? 2'b10 : 2'b01;
      MODE_NE:  r = eq ? 2'b01 : 2'b10;
      MODE_LT:  r = lt ? 2'b10 : 2'b01;
      MODE_GE:  r = lt ? 2'b01 : 2'b10;
      MODE_LTU: r = lt ? 2'b10 : 2'b01;
      MODE_GEU: r = lt ? 2'b01 : 2'b10;
      default:  r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_branch_seq_if.sv
// Request/result bundle of the branch comparator.
// master drives the request side, slave (the comparator) drives results.
interface cmp_branch_seq_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [2:0]       mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             taken;
  logic             notTaken;
  logic             fin;
  logic             err;
  logic             busy;

  modport master (
    output req, mode, x, y,
    input  taken, notTaken, fin, err, busy
  );

  modport slave (
    input  req, mode, x, y,
    output taken, notTaken, fin, err, busy
  );
endinterface

// File: rtl/cmp_branch_seq_chunk_cmp.sv
// One-chunk comparator: equality plus unsigned less-than, with an optional
// sign-bit flip so the top chunk of a signed operand orders correctly.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             inv_msb_i,
  output logic             eq_o,
  output logic             lt_o
);
  logic [CHUNK-1:0] flip_s;
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;

  assign flip_s = {inv_msb_i, {(CHUNK-1){1'b0}}};
  assign a_s    = a_i ^ flip_s;
  assign b_s    = b_i ^ flip_s;
  assign eq_o   = (a_i == b_i);
  assign lt_o   = (a_s < b_s);
endmodule

// File: rtl/cmp_branch_seq.sv
// Sequential branch comparator: samples operands on a 4-phase request,
// walks them MSB-chunk first and stops at the first differing chunk.
module cmp_branch_seq
  import cmp_branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  cmp_branch_seq_if.slave  bus
);
  localparam int NC = WIDTH / CHUNK;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NC - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("cmp_branch_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [2:0]       mode_q, mode_d;
  logic             taken_q, taken_d;
  logic             nt_q, nt_d;
  logic             err_q, err_d;

  logic [CHUNK-1:0] xch_s [NC];
  logic [CHUNK-1:0] ych_s [NC];
  logic             eq_s;
  logic             lt_s;
  logic             inv_msb_s;

  for (genvar g = 0; g < NC; g++) begin : g_chunks
    assign xch_s[g] = xs_q[g*CHUNK +: CHUNK];
    assign ych_s[g] = ys_q[g*CHUNK +: CHUNK];
  end

  assign inv_msb_s = is_signed_mode(mode_q) && (idx_q == IDX_TOP);

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i       (xch_s[idx_q]),
    .b_i       (ych_s[idx_q]),
    .inv_msb_i (inv_msb_s),
    .eq_o      (eq_s),
    .lt_o      (lt_s)
  );

  // State, latched operands, chunk index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      mode_q  <= 3'b000;
      taken_q <= 1'b0;
      nt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      mode_q  <= mode_d;
      taken_q <= taken_d;
      nt_q    <= nt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and result logic; an abort in CMP wins over resolution.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    mode_d  = mode_q;
    taken_d = taken_q;
    nt_d    = nt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          mode_d  = bus.mode;
          idx_d   = IDX_TOP;
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (!bus.req) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (is_reserved(mode_q)) begin
          taken_d = 1'b0;
          nt_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!eq_s || (idx_q == '0)) begin
          {taken_d, nt_d} = resolve(mode_q, eq_s, lt_s);
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        if (!bus.req) begin
          taken_d = 1'b0;
          nt_d    = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        taken_d = 1'b0;
        nt_d    = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.taken    = taken_q;
  assign bus.notTaken = nt_q;
  assign bus.fin      = taken_q | nt_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
